// File: rtl/audio_volume_ramp.sv
// Volume ramp sequencer: walks the multiplier gain toward a requested target
// one bounded step per divided sample tick, to avoid zipper noise.
// Optional mute support is compiled in with AUDIO_VOLUME_RAMP_MUTE_EN.
module audio_volume_ramp #(
  parameter int unsigned VOL_BIT = 8,
  parameter int unsigned STEP    = 1,
  parameter int unsigned DIV_BIT = 8
) (
  input  logic               CLK,
  input  logic               RST_N,
  input  logic               tick,
  input  logic [VOL_BIT-1:0] tgt_vol,
  input  logic               tgt_valid,
  output logic               tgt_ready,
  input  logic [DIV_BIT-1:0] rate_div,
`ifdef AUDIO_VOLUME_RAMP_MUTE_EN
  input  logic               mute,
  output logic               muted,
`endif
  output logic [VOL_BIT-1:0] Volume,
  output logic               busy,
  output logic               done
);

  localparam int unsigned VW = VOL_BIT + 1;
  localparam logic [VW-1:0] STEP_W = VW'(STEP);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RAMP = 2'd1
`ifdef AUDIO_VOLUME_RAMP_MUTE_EN
    , S_MUTE = 2'd2
`endif
  } state_t;

  state_t               state_q;
  logic [VOL_BIT-1:0]   tgt_q;
  logic [DIV_BIT-1:0]   div_q;
  logic [DIV_BIT-1:0]   cnt_q;

  logic [VOL_BIT-1:0]   aim_c;
  logic [VW-1:0]        vol_ext_c;
  logic [VW-1:0]        aim_ext_c;
  logic [VW-1:0]        diff_c;
  logic [VW-1:0]        step_c;
  logic                 up_c;
  logic [VOL_BIT-1:0]   vol_next_c;
  logic                 accept_c;
  logic                 div_hit_c;
  logic [DIV_BIT-1:0]   rate_eff_c;

  assign accept_c   = tgt_valid && tgt_ready;
  assign div_hit_c  = tick && (cnt_q == (div_q - DIV_BIT'(1)));
  assign rate_eff_c = (rate_div == '0) ? DIV_BIT'(1) : rate_div;

  // Next gain one step toward the aim point, clamped so it never overshoots
  always_comb begin
    aim_c = tgt_q;
`ifdef AUDIO_VOLUME_RAMP_MUTE_EN
    if (state_q == S_MUTE) aim_c = '0;
`endif
    vol_ext_c  = VW'(Volume);
    aim_ext_c  = VW'(aim_c);
    up_c       = (aim_ext_c >= vol_ext_c);
    diff_c     = up_c ? (aim_ext_c - vol_ext_c) : (vol_ext_c - aim_ext_c);
    step_c     = (diff_c > STEP_W) ? STEP_W : diff_c;
    vol_next_c = up_c ? VOL_BIT'(vol_ext_c + step_c) : VOL_BIT'(vol_ext_c - step_c);
  end

  // Ramp state machine with registered handshake, status and gain outputs
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_q   <= S_IDLE;
      tgt_q     <= '0;
      div_q     <= DIV_BIT'(1);
      cnt_q     <= '0;
      Volume    <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
      tgt_ready <= 1'b1;
`ifdef AUDIO_VOLUME_RAMP_MUTE_EN
      muted     <= 1'b0;
`endif
    end else begin
      done <= 1'b0;
`ifdef AUDIO_VOLUME_RAMP_MUTE_EN
      muted <= 1'b0;
      if (mute && (state_q != S_MUTE)) begin
        // Abort whatever is in flight; a target handshaking this cycle is kept
        if (accept_c) tgt_q <= tgt_vol;
        state_q   <= S_MUTE;
        busy      <= 1'b0;
        tgt_ready <= 1'b1;
        cnt_q     <= '0;
        muted     <= (Volume == '0);
      end else
`endif
      begin
        case (state_q)
          S_IDLE: begin
            if (accept_c) begin
              tgt_q <= tgt_vol;
              div_q <= rate_eff_c;
              cnt_q <= '0;
              if (tgt_vol == Volume) begin
                done <= 1'b1;
              end else begin
                state_q   <= S_RAMP;
                busy      <= 1'b1;
                tgt_ready <= 1'b0;
              end
            end
          end
          S_RAMP: begin
            if (div_hit_c) begin
              Volume <= vol_next_c;
              cnt_q  <= '0;
              if (vol_next_c == tgt_q) begin
                state_q   <= S_IDLE;
                busy      <= 1'b0;
                tgt_ready <= 1'b1;
                done      <= 1'b1;
              end
            end else if (tick) begin
              cnt_q <= cnt_q + DIV_BIT'(1);
            end
          end
`ifdef AUDIO_VOLUME_RAMP_MUTE_EN
          S_MUTE: begin
            tgt_ready <= 1'b1;
            busy      <= 1'b0;
            if (!mute) begin
              // Resume toward the most recent target, taking one arriving now
              cnt_q <= '0;
              if (accept_c) tgt_q <= tgt_vol;
              if ((accept_c ? tgt_vol : tgt_q) == Volume) begin
                state_q <= S_IDLE;
                done    <= 1'b1;
              end else begin
                state_q   <= S_RAMP;
                busy      <= 1'b1;
                tgt_ready <= 1'b0;
              end
            end else begin
              if (accept_c) tgt_q <= tgt_vol;
              if (div_hit_c) begin
                Volume <= vol_next_c;
                cnt_q  <= '0;
                muted  <= (vol_next_c == '0);
              end else begin
                if (tick) cnt_q <= cnt_q + DIV_BIT'(1);
                muted <= (Volume == '0);
              end
            end
          end
`endif
          default: begin
            state_q   <= S_IDLE;
            busy      <= 1'b0;
            tgt_ready <= 1'b1;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_audio_volume_ramp.sv
// Bench for audio_volume_ramp: two instances (STEP=1 and STEP=16) driven by a
// vector table, hand sequences for reset/hold corners, and random targets
// checked against a closed-form trajectory model.
module tb_audio_volume_ramp;

  logic             clk;
  logic             rst_n;
  logic [1:0]       tick;
  logic [1:0]       tgt_valid;
  logic [1:0]       tgt_ready;
  logic [1:0]       busy;
  logic [1:0]       done;
  logic [1:0][7:0]  tgt_vol;
  logic [1:0][7:0]  rate_div;
  logic [1:0][7:0]  vol;
`ifdef AUDIO_VOLUME_RAMP_MUTE_EN
  logic [1:0]       mute;
  logic [1:0]       muted;
`endif

  int vectors;
  int miscompares;

  audio_volume_ramp #(.VOL_BIT(8), .STEP(1), .DIV_BIT(8)) dut0 (
    .CLK(clk), .RST_N(rst_n), .tick(tick[0]), .tgt_vol(tgt_vol[0]),
    .tgt_valid(tgt_valid[0]), .tgt_ready(tgt_ready[0]), .rate_div(rate_div[0]),
`ifdef AUDIO_VOLUME_RAMP_MUTE_EN
    .mute(mute[0]), .muted(muted[0]),
`endif
    .Volume(vol[0]), .busy(busy[0]), .done(done[0])
  );

  audio_volume_ramp #(.VOL_BIT(8), .STEP(16), .DIV_BIT(8)) dut1 (
    .CLK(clk), .RST_N(rst_n), .tick(tick[1]), .tgt_vol(tgt_vol[1]),
    .tgt_valid(tgt_valid[1]), .tgt_ready(tgt_ready[1]), .rate_div(rate_div[1]),
`ifdef AUDIO_VOLUME_RAMP_MUTE_EN
    .mute(mute[1]), .muted(muted[1]),
`endif
    .Volume(vol[1]), .busy(busy[1]), .done(done[1])
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: actual timeout required finish");
    $fatal(1);
  end

  typedef struct {
    int sel;
    int tgt;
    int rate;
    int gap;
    int exp_ticks;
  } vec_t;

  task automatic chk(input string name, input int act, input int exp);
    vectors++;
    if (act != exp) begin
      miscompares++;
      $display("FAIL %s: actual %0d required %0d", name, act, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    @(negedge clk);
  endtask

  // Gain after nsteps divided ticks: linear move of STEP per step, clamped at target
  function automatic int model_vol(input int start, input int tgt, input int step, input int nsteps);
    int mag, mv;
    mag = (tgt >= start) ? tgt - start : start - tgt;
    mv  = step * nsteps;
    if (mv > mag) mv = mag;
    return (tgt >= start) ? start + mv : start - mv;
  endfunction

  // Ticks for a full ramp: ceil(|diff|/STEP) * effective divider
  function automatic int model_ticks(input int start, input int tgt, input int step, input int rate);
    int mag;
    mag = (tgt >= start) ? tgt - start : start - tgt;
    return ((mag + step - 1) / step) * ((rate == 0) ? 1 : rate);
  endfunction

  task automatic run_ramp(input int sel, input int tgt, input int rate, input int gap, input int exp_ticks);
    int start, step, div, n, ev;
    bit landed;
    step = (sel != 0) ? 16 : 1;
    div  = (rate == 0) ? 1 : rate;
    for (int w = 0; w < 100 && !tgt_ready[sel]; w++) cyc();
    chk("ready_before_req", int'(tgt_ready[sel]), 1);
    start = int'(vol[sel]);
    tgt_vol[sel]   = 8'(tgt);
    rate_div[sel]  = 8'(rate);
    tgt_valid[sel] = 1'b1;
    tick[sel]      = 1'b1;
    cyc();
    tgt_valid[sel] = 1'b0;
    tick[sel]      = 1'b0;
    rate_div[sel]  = 8'($urandom_range(0, 255));
    if (tgt == start) begin
      chk("equal_done", int'(done[sel]), 1);
      chk("equal_busy", int'(busy[sel]), 0);
      chk("equal_ready", int'(tgt_ready[sel]), 1);
      cyc();
      chk("equal_done_drop", int'(done[sel]), 0);
      return;
    end
    chk("accept_busy", int'(busy[sel]), 1);
    chk("accept_ready", int'(tgt_ready[sel]), 0);
    chk("accept_vol", int'(vol[sel]), start);
    n = 0;
    landed = 1'b0;
    ev = start;
    while (!landed && n < exp_ticks + 2) begin
      for (int g = 1; g < gap; g++) begin
        cyc();
        chk("no_tick_hold", int'(vol[sel]), ev);
      end
      tick[sel] = 1'b1;
      cyc();
      tick[sel] = 1'b0;
      n++;
      ev = model_vol(start, tgt, step, n / div);
      chk("ramp_vol", int'(vol[sel]), ev);
      if (ev == tgt) begin
        landed = 1'b1;
        chk("land_done", int'(done[sel]), 1);
        chk("land_busy", int'(busy[sel]), 0);
        chk("land_ready", int'(tgt_ready[sel]), 1);
      end else begin
        chk("mid_done", int'(done[sel]), 0);
        chk("mid_busy", int'(busy[sel]), 1);
      end
    end
    chk("ramp_ticks", n, exp_ticks);
    cyc();
    chk("done_one_cycle", int'(done[sel]), 0);
  endtask

  vec_t table_v[11];

  initial begin
    int cur, tgt, cnt, sel, rate;
    vectors = 0;
    miscompares = 0;
    table_v[0]  = '{0,  10, 1, 4, 10};
    table_v[1]  = '{1, 200, 1, 1, 13};
    table_v[2]  = '{0,  10, 5, 1,  0};
    table_v[3]  = '{1,   5, 3, 2, 39};
    table_v[4]  = '{0,   3, 0, 2,  7};
    table_v[5]  = '{1, 128, 1, 1,  8};
    table_v[6]  = '{0,   8, 2, 1, 10};
    table_v[7]  = '{1, 128, 2, 1,  0};
    table_v[8]  = '{1, 255, 2, 1, 16};
    table_v[9]  = '{1,   0, 1, 1, 16};
    table_v[10] = '{0,   0, 1, 3,  8};

    rst_n = 1'b0;
    tick = '0;
    tgt_valid = '0;
    tgt_vol = '0;
    rate_div = '0;
`ifdef AUDIO_VOLUME_RAMP_MUTE_EN
    mute = '0;
`endif
    #12;
    for (int s = 0; s < 2; s++) begin
      chk("reset_vol", int'(vol[s]), 0);
      chk("reset_busy", int'(busy[s]), 0);
      chk("reset_ready", int'(tgt_ready[s]), 1);
      chk("reset_done", int'(done[s]), 0);
    end
    @(negedge clk);
    rst_n = 1'b1;
    cyc();

    for (int i = 0; i < 11; i++)
      run_ramp(table_v[i].sel, table_v[i].tgt, table_v[i].rate, table_v[i].gap, table_v[i].exp_ticks);

    // Held request during a ramp waits for ready and leaves the first ramp intact
    tgt_vol[0] = 8'd20; rate_div[0] = 8'd1; tgt_valid[0] = 1'b1;
    cyc();
    tgt_vol[0] = 8'd5;
    for (int n = 1; n <= 20; n++) begin
      tick[0] = 1'b1;
      cyc();
      tick[0] = 1'b0;
      chk("hold_vol", int'(vol[0]), n);
      chk("hold_ready", int'(tgt_ready[0]), (n == 20) ? 1 : 0);
    end
    chk("hold_done", int'(done[0]), 1);
    cyc();
    tgt_valid[0] = 1'b0;
    chk("hold_second_busy", int'(busy[0]), 1);
    chk("hold_second_vol", int'(vol[0]), 20);
    cnt = 0;
    while (!done[0] && cnt < 20) begin
      tick[0] = 1'b1;
      cyc();
      tick[0] = 1'b0;
      cnt++;
    end
    chk("hold_second_ticks", cnt, 15);
    chk("hold_second_vol_end", int'(vol[0]), 5);

    // Asynchronous reset in the middle of a ramp
    tgt_vol[0] = 8'd50; rate_div[0] = 8'd1; tgt_valid[0] = 1'b1;
    cyc();
    tgt_valid[0] = 1'b0;
    cnt = 0;
    while (vol[0] != 8'd37 && cnt < 60) begin
      tick[0] = 1'b1;
      cyc();
      tick[0] = 1'b0;
      cnt++;
    end
    chk("pre_reset_vol", int'(vol[0]), 37);
    #2;
    rst_n = 1'b0;
    #1;
    chk("midreset_vol", int'(vol[0]), 0);
    chk("midreset_busy", int'(busy[0]), 0);
    chk("midreset_ready", int'(tgt_ready[0]), 1);
    chk("midreset_done", int'(done[0]), 0);
    @(negedge clk);
    rst_n = 1'b1;
    for (int k = 0; k < 3; k++) begin
      cyc();
      chk("post_reset_no_done", int'(done[0]), 0);
    end

    // Random targets against the closed-form model
    for (int i = 0; i < 24; i++) begin
      sel = int'($urandom_range(0, 1));
      cur = int'(vol[sel]);
      if (sel == 0) begin
        tgt = cur + int'($urandom_range(0, 40)) - 20;
        if (tgt < 0) tgt = 0;
        if (tgt > 255) tgt = 255;
      end else begin
        tgt = int'($urandom_range(0, 255));
      end
      rate = int'($urandom_range(0, 3));
      run_ramp(sel, tgt, rate, int'($urandom_range(1, 3)),
               model_ticks(cur, tgt, (sel != 0) ? 16 : 1, rate));
    end

`ifdef AUDIO_VOLUME_RAMP_MUTE_EN
    run_ramp(0, 100, 1, 1, model_ticks(int'(vol[0]), 100, 1, 1));
    tgt_vol[0] = 8'd150; rate_div[0] = 8'd1; tgt_valid[0] = 1'b1;
    cyc();
    tgt_valid[0] = 1'b0;
    for (int k = 0; k < 3; k++) begin
      tick[0] = 1'b1;
      cyc();
      tick[0] = 1'b0;
    end
    chk("mute_pre_vol", int'(vol[0]), 103);
    mute[0] = 1'b1;
    cyc();
    chk("mute_busy", int'(busy[0]), 0);
    chk("mute_ready", int'(tgt_ready[0]), 1);
    chk("mute_done", int'(done[0]), 0);
    cnt = 0;
    while (vol[0] != 8'd0 && cnt < 120) begin
      tick[0] = 1'b1;
      cyc();
      tick[0] = 1'b0;
      cnt++;
      chk("mute_fall_vol", int'(vol[0]), 103 - cnt);
    end
    chk("mute_fall_ticks", cnt, 103);
    chk("muted_flag", int'(muted[0]), 1);
    tgt_vol[0] = 8'd60; tgt_valid[0] = 1'b1;
    cyc();
    tgt_valid[0] = 1'b0;
    chk("mute_accept_nodone", int'(done[0]), 0);
    for (int k = 0; k < 3; k++) begin
      tick[0] = 1'b1;
      cyc();
      tick[0] = 1'b0;
      chk("mute_stay_zero", int'(vol[0]), 0);
    end
    mute[0] = 1'b0;
    cyc();
    chk("unmute_busy", int'(busy[0]), 1);
    chk("unmute_muted", int'(muted[0]), 0);
    cnt = 0;
    while (!done[0] && cnt < 80) begin
      tick[0] = 1'b1;
      cyc();
      tick[0] = 1'b0;
      cnt++;
    end
    chk("unmute_ticks", cnt, 60);
    chk("unmute_vol", int'(vol[0]), 60);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
